// File: rtl/memory_map_pkg.sv
// rtl/memory_map_pkg.sv - region, state and size definitions shared by the memory bus arbiter
package memory_map_pkg;

    typedef enum logic [2:0] {
        REGION_INSTR,
        REGION_CACHE,
        REGION_UNMAPPED,
        REGION_IO,
        REGION_RAM
    } region_t;

    localparam logic [31:0] IO_BASE  = 32'h0000_1000;
    localparam logic [31:0] RAM_BASE = 32'h0000_4000;

    typedef logic [1:0] arb_state_t;
    localparam arb_state_t IDLE     = 2'd0;
    localparam arb_state_t ACCESS   = 2'd1;
    localparam arb_state_t RAM_WAIT = 2'd2;
    localparam arb_state_t COMPLETE = 2'd3;

    localparam logic [1:0] SIZE_BYTE    = 2'd0;
    localparam logic [1:0] SIZE_HALF    = 2'd1;
    localparam logic [1:0] SIZE_WORD    = 2'd2;
    localparam logic [1:0] SIZE_ILLEGAL = 2'd3;

    // Size code 3 is folded in here so callers see a single "bad access shape" flag.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] low_bits);
        case (size)
            SIZE_BYTE: is_misaligned = 1'b0;
            SIZE_HALF: is_misaligned = low_bits[0];
            SIZE_WORD: is_misaligned = (low_bits != 2'b00);
            default:   is_misaligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/memory_region_decoder.sv
// rtl/memory_region_decoder.sv - combinational address/size to region and misalignment decode
module memory_region_decoder
    import memory_map_pkg::*;
#(
    parameter int INSTR_BITS = 10,
    parameter int CACHE_BITS = 10
) (
    input  logic [31:0] address,
    input  logic [1:0]  size,
    output region_t     region,
    output logic        misaligned
);

    localparam logic [31:0] INSTR_LIMIT = 32'(1) << INSTR_BITS;
    localparam logic [31:0] CACHE_LIMIT = 32'(1) << (CACHE_BITS + 1);

    always_comb begin
        if (address < INSTR_LIMIT) begin
            region = REGION_INSTR;
        end else if (address < CACHE_LIMIT) begin
            region = REGION_CACHE;
        end else if (address < IO_BASE) begin
            region = REGION_UNMAPPED;
        end else if (address < RAM_BASE) begin
            region = REGION_IO;
        end else begin
            region = REGION_RAM;
        end
    end

    assign misaligned = is_misaligned(size, address[1:0]);

endmodule

// File: rtl/memory_bus_arbiter.sv
// rtl/memory_bus_arbiter.sv - two-master round-robin arbiter sequencing one memory transaction at a time
module memory_bus_arbiter
    import memory_map_pkg::*;
#(
    parameter int INSTR_BITS  = 10,
    parameter int CACHE_BITS  = 10,
    parameter int RAM_TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        m0_valid,
    input  logic [31:0] m0_address,
    input  logic [1:0]  m0_size,
    input  logic        m0_write,
    input  logic [31:0] m0_write_value,
    output logic        m0_ready,
    output logic        m0_error,
    output logic [31:0] m0_read_value,

    input  logic        m1_valid,
    input  logic [31:0] m1_address,
    input  logic [1:0]  m1_size,
    input  logic        m1_write,
    input  logic [31:0] m1_write_value,
    output logic        m1_ready,
    output logic        m1_error,
    output logic [31:0] m1_read_value,

    output logic [31:0] mem_address,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_write_value,
    output logic        instr_write_enable,
    output logic        cache_write_enable,
    output logic        io_write_enable,
    input  logic [31:0] instr_read_value,
    input  logic [31:0] cache_read_value,
    input  logic [31:0] io_read_value,

    output logic        ram_req,
    input  logic        ram_ack,
    input  logic [31:0] ram_read_value,

    output logic        busy
);

    arb_state_t  state;
    logic        last_grant;
    logic        grant;
    logic [31:0] lat_address;
    logic [1:0]  lat_size;
    logic        lat_write;
    logic [31:0] lat_write_value;
    region_t     lat_region;
    logic        err_flag;
    logic [7:0]  ram_count;
    logic [31:0] ram_data;

    logic        grant_next;
    logic [31:0] req_address;
    logic [1:0]  req_size;
    logic        req_write;
    logic [31:0] req_write_value;
    region_t     req_region;
    logic        req_misaligned;
    logic        req_error;

    // Tie goes to the master that did not win last time; last_grant resets to 1 so m0 wins first.
    always_comb begin
        if (m0_valid && m1_valid) begin
            grant_next = ~last_grant;
        end else begin
            grant_next = m1_valid;
        end
    end

    assign req_address     = grant_next ? m1_address     : m0_address;
    assign req_size        = grant_next ? m1_size        : m0_size;
    assign req_write       = grant_next ? m1_write       : m0_write;
    assign req_write_value = grant_next ? m1_write_value : m0_write_value;

    memory_region_decoder #(
        .INSTR_BITS (INSTR_BITS),
        .CACHE_BITS (CACHE_BITS)
    ) u_decoder (
        .address    (req_address),
        .size       (req_size),
        .region     (req_region),
        .misaligned (req_misaligned)
    );

    // The CPU port may never overwrite the instruction bank; only the loader can.
    assign req_error = req_misaligned
                    || (req_region == REGION_UNMAPPED)
                    || (!grant_next && req_write && (req_region == REGION_INSTR));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            last_grant      <= 1'b1;
            grant           <= 1'b0;
            lat_address     <= '0;
            lat_size        <= '0;
            lat_write       <= 1'b0;
            lat_write_value <= '0;
            lat_region      <= REGION_INSTR;
            err_flag        <= 1'b0;
            ram_count       <= '0;
            ram_data        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_valid || m1_valid) begin
                        grant           <= grant_next;
                        last_grant      <= grant_next;
                        lat_address     <= req_address;
                        lat_size        <= req_size;
                        lat_write       <= req_write;
                        lat_write_value <= req_write_value;
                        lat_region      <= req_region;
                        err_flag        <= req_error;
                        ram_count       <= '0;
                        ram_data        <= '0;
                        if (req_error) begin
                            state <= COMPLETE;
                        end else if (req_region == REGION_RAM) begin
                            state <= RAM_WAIT;
                        end else begin
                            state <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    state <= COMPLETE;
                end
                RAM_WAIT: begin
                    if (ram_ack) begin
                        ram_data <= ram_read_value;
                        state    <= COMPLETE;
                    end else if (ram_count == 8'(RAM_TIMEOUT)) begin
                        err_flag <= 1'b1;
                        state    <= COMPLETE;
                    end else begin
                        ram_count <= ram_count + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    logic        in_access;
    logic        in_complete;
    logic [31:0] sel_read;
    logic [31:0] resp_data;

    assign in_access   = (state == ACCESS) && lat_write;
    assign in_complete = (state == COMPLETE);

    assign mem_address        = lat_address;
    assign mem_size           = lat_size;
    assign mem_write_value    = lat_write_value;
    assign instr_write_enable = in_access && (lat_region == REGION_INSTR);
    assign cache_write_enable = in_access && (lat_region == REGION_CACHE);
    assign io_write_enable    = in_access && (lat_region == REGION_IO);
    assign ram_req            = (state == RAM_WAIT);
    assign busy               = (state != IDLE);

    always_comb begin
        case (lat_region)
            REGION_INSTR: sel_read = instr_read_value;
            REGION_CACHE: sel_read = cache_read_value;
            REGION_IO:    sel_read = io_read_value;
            REGION_RAM:   sel_read = ram_data;
            default:      sel_read = '0;
        endcase
    end

    assign resp_data = (in_complete && !lat_write && !err_flag) ? sel_read : '0;

    assign m0_ready      = in_complete && !grant;
    assign m1_ready      = in_complete && grant;
    assign m0_error      = m0_ready && err_flag;
    assign m1_error      = m1_ready && err_flag;
    assign m0_read_value = m0_ready ? resp_data : '0;
    assign m1_read_value = m1_ready ? resp_data : '0;

endmodule
